multicycle_ctrl: RTL and testbench

Multi-cycle sequencer for the RISC core. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, using the 5-bit opcode classes that the main decoder also consumes. It issues one-cycle enables for the instruction register, PC, register file and memories, and uses req/ready handshakes to the instruction and data memories. The main decoder still drives the datapath muxes; this block only sets when each stage fires.

---
 rtl/multicycle_ctrl_pkg.sv | 61 ++++++
 rtl/multicycle_ctrl_if.sv | 25 ++
 rtl/multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared definitions for the multi-cycle sequencer: state
//               encodings, opcode classes (shared with main_decoder) and the
//               PC source select constants.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  // Sequencer states; encodings are visible on the debug state port
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_ERR    = 3'd6
  } state_e;

  // Opcode field values, identical to the ones main_decoder consumes
  localparam logic [4:0] OP_R4   = 5'b01101;
  localparam logic [4:0] OP_R3   = 5'b00011;
  localparam logic [4:0] OP_R2   = 5'b00001;
  localparam logic [4:0] OP_MOV  = 5'b00101;
  localparam logic [4:0] OP_I    = 5'b11101;
  localparam logic [4:0] OP_LW   = 5'b10111;
  localparam logic [4:0] OP_SW   = 5'b10001;
  localparam logic [4:0] OP_BR   = 5'b01010;
  localparam logic [4:0] OP_JAL  = 5'b11110;
  localparam logic [4:0] OP_JALR = 5'b01111;

  // PC source select
  localparam logic [1:0] PC_SEL_PLUS4  = 2'b00;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b10;

  // Coarse opcode classes: only what the sequencer needs to pick a path
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_LOAD    = 3'd1,
    CLS_STORE   = 3'd2,
    CLS_BRANCH  = 3'd3,
    CLS_JUMP    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_R4, OP_R3, OP_R2, OP_MOV, OP_I: return CLS_ALU;
      OP_LW:                             return CLS_LOAD;
      OP_SW:                             return CLS_STORE;
      OP_BR:                             return CLS_BRANCH;
      OP_JAL, OP_JALR:                   return CLS_JUMP;
      default:                           return CLS_ILLEGAL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Instruction/data memory request-ready handshake between the
//               sequencer (master) and the memory side (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req, dmem_req, dmem_we,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, dmem_we,
    output imem_ready, dmem_ready
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle instruction sequencer. Steps each instruction
//               through FETCH/DECODE/EXEC/MEM/WB, issues one-cycle enables
//               and handles memory req/ready handshakes.
//               Optional macro MEM_TIMEOUT_EN: bounded MEM wait with a sticky
//               fault flag and a reset-only ERR state.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             run,
  input  wire logic [4:0]       opcode,
  input  wire logic             zero,
  multicycle_ctrl_if.master     mem,
  output logic                  ir_load,
  output logic                  pc_load,
  output logic [1:0]            pc_sel,
  output logic                  rf_we,
  output logic [2:0]            state,
  output logic                  illegal_op,
  output logic [CNT_W-1:0]      instr_count,
  output logic                  fault
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  op_class_e         w_cls;
  logic              w_retire;

`ifdef MEM_TIMEOUT_EN
  localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);
  logic [3:0]        wait_q, wait_d;
  logic              fault_q, fault_d;
`else
  logic [3:0]        w_timeout_unused;
  assign w_timeout_unused = 4'(TIMEOUT);
`endif

  // Opcode is stable from DECODE onward, so it is classified directly
  assign w_cls = classify(opcode);

  // Next state, retire decision and state-decoded strobes
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    w_retire     = 1'b0;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_load      = 1'b0;
    pc_load      = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    rf_we        = 1'b0;
    illegal_op   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_d       = 4'd0;
    fault_d      = fault_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        mem.imem_req = 1'b1;
        if (mem.imem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        // Unknown opcodes retire as a NOP so the PC still advances
        if (w_cls == CLS_ILLEGAL) begin
          illegal_op = 1'b1;
          pc_load    = 1'b1;
          w_retire   = 1'b1;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (w_cls)
          CLS_BRANCH: begin
            pc_load  = 1'b1;
            pc_sel   = zero ? PC_SEL_BRANCH : PC_SEL_PLUS4;
            w_retire = 1'b1;
          end
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          default:             state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = (w_cls == CLS_STORE);
        if (mem.dmem_ready) begin
          if (w_cls == CLS_STORE) begin
            pc_load  = 1'b1;
            w_retire = 1'b1;
          end else begin
            state_d = ST_WB;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (wait_q == WAIT_LAST) begin
          state_d = ST_ERR;
          fault_d = 1'b1;
        end else begin
          wait_d = wait_q + 4'd1;
        end
`endif
      end

      ST_WB: begin
        rf_we    = 1'b1;
        pc_load  = 1'b1;
        pc_sel   = (w_cls == CLS_JUMP) ? PC_SEL_JUMP : PC_SEL_PLUS4;
        w_retire = 1'b1;
      end

      // ERR is a quiet trap left only through reset
      ST_ERR: state_d = ST_ERR;

      default: state_d = ST_IDLE;
    endcase

    // run is only looked at on the instruction boundary
    if (w_retire) begin
      count_d = count_q + CNT_W'(1);
      state_d = run ? ST_FETCH : ST_IDLE;
    end
  end

  // State, retire counter and optional timeout bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      count_q <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_q  <= 4'd0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
`ifdef MEM_TIMEOUT_EN
      wait_q  <= wait_d;
      fault_q <= fault_d;
`endif
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;
`ifdef MEM_TIMEOUT_EN
  assign fault       = fault_q;
`else
  assign fault       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl; per-instruction
//               cycle traces are built from the stage rules and compared
//               cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TB_CNT_W   = 4;
  localparam int TB_TIMEOUT = 15;

  localparam int K_ALU = 0, K_LW = 1, K_SW = 2, K_BR = 3, K_JMP = 4, K_ILL = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                run;
  logic [4:0]          opcode;
  logic                zero;
  logic                ir_load, pc_load, rf_we, illegal_op, fault;
  logic [1:0]          pc_sel;
  logic [2:0]          state;
  logic [TB_CNT_W-1:0] instr_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_count = 0;
  logic at_fetch = 1'b0;

  multicycle_ctrl_if mem_if();

  multicycle_ctrl #(.CNT_W(TB_CNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .opcode      (opcode),
    .zero        (zero),
    .mem         (mem_if),
    .ir_load     (ir_load),
    .pc_load     (pc_load),
    .pc_sel      (pc_sel),
    .rf_we       (rf_we),
    .state       (state),
    .illegal_op  (illegal_op),
    .instr_count (instr_count),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  typedef struct {
    logic [11:0] outs;
    logic        in_fetch;
    logic        in_mem;
    logic        rdy;
  } cyc_t;

  function automatic int op_kind(input logic [4:0] op);
    case (op)
      5'b01101, 5'b00011, 5'b00001, 5'b00101, 5'b11101: return K_ALU;
      5'b10111: return K_LW;
      5'b10001: return K_SW;
      5'b01010: return K_BR;
      5'b11110, 5'b01111: return K_JMP;
      default:  return K_ILL;
    endcase
  endfunction

  // {state, imem_req, ir_load, dmem_req, dmem_we, pc_load, pc_sel, rf_we, illegal_op}
  function automatic logic [11:0] ev(input logic [2:0] st, input logic ireq, input logic irl,
                                     input logic dreq, input logic dwe, input logic pcl,
                                     input logic [1:0] ps, input logic rfw, input logic ill);
    return {st, ireq, irl, dreq, dwe, pcl, ps, rfw, ill};
  endfunction

  function automatic logic [11:0] observed();
    return {state, mem_if.imem_req, ir_load, mem_if.dmem_req, mem_if.dmem_we,
            pc_load, pc_sel, rf_we, illegal_op};
  endfunction

  // Entered just after a rising edge with the DUT in IDLE; leaves it in FETCH
  task automatic start_from_idle(input string tag);
    run = 1'b1;
    mem_if.imem_ready = 1'($urandom);
    mem_if.dmem_ready = 1'($urandom);
    opcode = 5'($urandom);
    zero = 1'($urandom);
    @(negedge clk);
    n_checks++;
    if (observed() !== ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0))
      $display("FAIL %s idle_start: got %b want %b", tag, observed(), ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    else n_pass++;
    @(posedge clk); #1;
    at_fetch = 1'b1;
  endtask

  // Entered just after a rising edge with the DUT in FETCH; runs one instruction
  task automatic run_instr(input logic [4:0] op, input logic zv, input int iw, input int dw,
                           input logic run_end, input string tag);
    cyc_t tr[$];
    int   k;
    logic last;
    k = op_kind(op);
    for (int j = 0; j <= iw; j++)
      tr.push_back('{ev(3'd1, 1, j == iw, 0, 0, 0, 2'b00, 0, 0), 1'b1, 1'b0, j == iw});
    if (k == K_ILL) begin
      tr.push_back('{ev(3'd2, 0, 0, 0, 0, 1, 2'b00, 0, 1), 1'b0, 1'b0, 1'b0});
    end else begin
      tr.push_back('{ev(3'd2, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0, 1'b0});
      if (k == K_BR) begin
        tr.push_back('{ev(3'd3, 0, 0, 0, 0, 1, zv ? 2'b01 : 2'b00, 0, 0), 1'b0, 1'b0, 1'b0});
      end else begin
        tr.push_back('{ev(3'd3, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0, 1'b0});
        if (k == K_LW || k == K_SW)
          for (int j = 0; j <= dw; j++)
            tr.push_back('{ev(3'd4, 0, 0, 1, k == K_SW, (k == K_SW) && (j == dw), 2'b00, 0, 0),
                           1'b0, 1'b1, j == dw});
        if (k != K_SW)
          tr.push_back('{ev(3'd5, 0, 0, 0, 0, 1, (k == K_JMP) ? 2'b10 : 2'b00, 1, 0),
                         1'b0, 1'b0, 1'b0});
      end
    end

    for (int i = 0; i < tr.size(); i++) begin
      last = (i == tr.size() - 1);
      run = last ? run_end : 1'($urandom);
      mem_if.imem_ready = tr[i].in_fetch ? tr[i].rdy : 1'($urandom);
      mem_if.dmem_ready = tr[i].in_mem ? tr[i].rdy : 1'($urandom);
      opcode = tr[i].in_fetch ? 5'($urandom) : op;
      zero = (tr[i].outs[11:9] == 3'd3) ? zv : 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (observed() !== tr[i].outs)
        $display("FAIL %s cycle%0d outputs: got %b want %b", tag, i, observed(), tr[i].outs);
      else n_pass++;
      @(posedge clk); #1;
    end

    exp_count = (exp_count + 1) % (1 << TB_CNT_W);
    n_checks++;
    if (state !== (run_end ? 3'd1 : 3'd0) || instr_count !== TB_CNT_W'(exp_count) || fault !== 1'b0)
      $display("FAIL %s retire: state=%0d count=%0d fault=%b want state=%0d count=%0d fault=0",
               tag, state, instr_count, fault, run_end ? 1 : 0, exp_count);
    else n_pass++;
    at_fetch = run_end;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; opcode = 5'd0; zero = 1'b0;
    mem_if.imem_ready = 1'b0; mem_if.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (observed() !== ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0) || instr_count !== '0 || fault !== 1'b0)
      $display("FAIL reset_state: got %b count=%0d fault=%b want all zero", observed(), instr_count, fault);
    else n_pass++;
    rst_n = 1'b1;
    exp_count = 0;
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0 || mem_if.imem_req !== 1'b0)
        $display("FAIL reset_idle_hold: state=%0d imem_req=%b want 0 0", state, mem_if.imem_req);
      else n_pass++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_r4();
    start_from_idle("r4");
    run_instr(5'b01101, 1'b0, 0, 0, 1'b0, "r4");
  endtask

  task automatic test_lw_delay();
    start_from_idle("lw");
    run_instr(5'b10111, 1'b0, 0, 3, 1'b0, "lw_delay3");
  endtask

  task automatic test_branch();
    start_from_idle("br");
    run_instr(5'b01010, 1'b1, 0, 0, 1'b1, "br_zero1");
    run_instr(5'b01010, 1'b0, 0, 0, 1'b0, "br_zero0");
  endtask

  task automatic test_illegal();
    start_from_idle("ill");
    run_instr(5'b11111, 1'b0, 0, 0, 1'b1, "illegal");
    run_instr(5'b00001, 1'b0, 1, 0, 1'b0, "after_illegal");
  endtask

  task automatic test_sw_run_drop();
    start_from_idle("sw");
    run_instr(5'b10001, 1'b0, 1, 2, 1'b0, "sw_run_drop");
    run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (state !== 3'd0 || mem_if.imem_req !== 1'b0)
        $display("FAIL sw_parked: state=%0d imem_req=%b want 0 0", state, mem_if.imem_req);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
`ifdef MEM_TIMEOUT_EN
    start_from_idle("tmo");
    opcode = 5'b10111; run = 1'b1; mem_if.dmem_ready = 1'b0;
    mem_if.imem_ready = 1'b1;
    @(posedge clk); #1;            // DECODE
    mem_if.imem_ready = 1'b0;
    @(posedge clk); #1;            // EXEC
    @(posedge clk); #1;            // first MEM cycle
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      @(negedge clk);
      n_checks++;
      if (state !== 3'd4 || mem_if.dmem_req !== 1'b1 || fault !== 1'b0)
        $display("FAIL tmo_wait%0d: state=%0d dmem_req=%b fault=%b want 4 1 0", i, state, mem_if.dmem_req, fault);
      else n_pass++;
      @(posedge clk); #1;
    end
    repeat (3) begin
      mem_if.dmem_ready = 1'($urandom); mem_if.imem_ready = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (observed() !== ev(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0) || fault !== 1'b1)
        $display("FAIL tmo_err: got %b fault=%b want %b fault=1", observed(), fault, ev(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0));
      else n_pass++;
      @(posedge clk); #1;
    end
    run = 1'b0;
    rst_n = 1'b0; #2;
    n_checks++;
    if (state !== 3'd0 || fault !== 1'b0)
      $display("FAIL tmo_clear: state=%0d fault=%b want 0 0", state, fault);
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    exp_count = 0;
    @(posedge clk); #1;
    at_fetch = 1'b0;
`else
    start_from_idle("lw_long");
    run_instr(5'b10111, 1'b0, 2, 20, 1'b0, "lw_long_wait");
`endif
  endtask

  task automatic test_reset_mid();
    start_from_idle("rst_mid");
    opcode = 5'b10111; mem_if.imem_ready = 1'b1; mem_if.dmem_ready = 1'b0; run = 1'b1;
    @(posedge clk); #1;            // DECODE
    @(posedge clk); #1;            // EXEC
    @(posedge clk); #1;            // MEM
    @(negedge clk);
    n_checks++;
    if (mem_if.dmem_req !== 1'b1)
      $display("FAIL rst_mid_pre: dmem_req=%b want 1", mem_if.dmem_req);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (observed() !== ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0) || instr_count !== '0)
      $display("FAIL rst_mid_abort: got %b count=%0d want %b count=0",
               observed(), instr_count, ev(3'd0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    else n_pass++;
    run = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_count = 0;
    @(posedge clk); #1;
    at_fetch = 1'b0;
  endtask

  task automatic test_random();
    logic [4:0] known [10];
    logic [4:0] op;
    known = '{5'b01101, 5'b00011, 5'b00001, 5'b00101, 5'b11101,
              5'b10111, 5'b10001, 5'b01010, 5'b11110, 5'b01111};
    for (int n = 0; n < 60; n++) begin
      if (!at_fetch) start_from_idle("rnd");
      op = ($urandom_range(0, 9) < 8) ? known[$urandom_range(0, 9)] : 5'($urandom);
      run_instr(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 3) != 0), "random");
    end
  endtask

  initial begin
    test_reset();
    test_r4();
    test_lw_delay();
    test_branch();
    test_illegal();
    test_sw_run_drop();
    test_mem_wait();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
